// File: rtl/mcu_arb_pkg.sv
// Shared types and constants for the MCU-side memory port arbiter.
// The state encoding, requester indices and counter widths live here.
package mcu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam int REQ_DMA     = 0;
    localparam int REQ_W       = 1;
    localparam int REQ_R       = 2;
    localparam int NUM_REQ     = 3;

    localparam int ACC_CNT_W   = 4;
    localparam int BURST_CNT_W = 8;

endpackage

// File: rtl/mcu_arb_slot.sv
// One pending request slot: captures address/data on a request pulse,
// holds it until granted, and flags a request that arrives while still full.
module mcu_arb_slot
    import mcu_arb_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_grant,
    output logic              o_pending,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_ovf
);

    logic              r_pending;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_capture;

    // A grant on the same edge frees the slot, so the new pulse re-arms it.
    assign w_capture = i_req & (~r_pending | i_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (w_capture) begin
            r_pending <= 1'b1;
        end else if (i_grant) begin
            r_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_addr <= i_addr;
            r_data <= i_data;
        end
    end

    assign o_pending = r_pending;
    assign o_addr    = r_addr;
    assign o_data    = r_data;
    assign o_ovf     = i_req & r_pending & ~i_grant;

endmodule

// File: rtl/mcu_mem_arb.sv
// Sequences the single MCU-side memory port between SD DMA writes, MCU writes
// and MCU reads, with DMA priority limited by a bounded burst counter.
module mcu_mem_arb
    import mcu_arb_pkg::*;
#(
    parameter int ADDR_W        = 24,
    parameter int ACCESS_CYCLES = 2,
    parameter int DMA_BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              slot_ok,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_data,
    output logic              dma_ack,
    input  logic              mcu_rrq,
    input  logic              mcu_wrq,
    input  logic [ADDR_W-1:0] mcu_addr,
    input  logic [7:0]        mcu_wdata,
    output logic [7:0]        mcu_rdata,
    output logic              mcu_rq_rdy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic              mem_oe,
    output logic              busy,
    output logic [2:0]        ovf,
    input  logic              ovf_clr
);

    localparam logic [ACC_CNT_W-1:0]   ACC_LOAD  = ACC_CNT_W'(ACCESS_CYCLES);
    localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(DMA_BURST_MAX);

    arb_state_t              r_state;
    arb_state_t              w_next_state;

    logic [NUM_REQ-1:0]      w_req;
    logic [NUM_REQ-1:0]      w_pend;
    logic [NUM_REQ-1:0]      w_grant;
    logic [NUM_REQ-1:0]      w_ovf_evt;
    logic [ADDR_W-1:0]       w_slot_addr [NUM_REQ];
    logic [7:0]              w_slot_data [NUM_REQ];
    logic [ADDR_W-1:0]       w_sel_addr;
    logic [7:0]              w_sel_data;
    logic                    w_mcu_pend;
    logic                    w_acc_last;

    logic [ADDR_W-1:0]       r_mem_addr;
    logic [7:0]              r_mem_wdata;
    logic                    r_mem_we;
    logic                    r_mem_oe;
    logic [ACC_CNT_W-1:0]    r_acc_cnt;
    logic [BURST_CNT_W-1:0]  r_burst_cnt;
    logic                    r_cur_dma;
    logic                    r_cur_rd;
    logic                    r_dma_ack;
    logic                    r_rq_rdy;
    logic [7:0]              r_rdata;
    logic [2:0]              r_ovf;

    assign w_req = {mcu_rrq, mcu_wrq, dma_req};

    mcu_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(8)) u_slot_dma (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (w_req[REQ_DMA]),
        .i_addr    (dma_addr),
        .i_data    (dma_data),
        .i_grant   (w_grant[REQ_DMA]),
        .o_pending (w_pend[REQ_DMA]),
        .o_addr    (w_slot_addr[REQ_DMA]),
        .o_data    (w_slot_data[REQ_DMA]),
        .o_ovf     (w_ovf_evt[REQ_DMA])
    );

    mcu_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(8)) u_slot_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (w_req[REQ_W]),
        .i_addr    (mcu_addr),
        .i_data    (mcu_wdata),
        .i_grant   (w_grant[REQ_W]),
        .o_pending (w_pend[REQ_W]),
        .o_addr    (w_slot_addr[REQ_W]),
        .o_data    (w_slot_data[REQ_W]),
        .o_ovf     (w_ovf_evt[REQ_W])
    );

    // Reads carry no data; the slot's data register just holds zero.
    mcu_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(8)) u_slot_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (w_req[REQ_R]),
        .i_addr    (mcu_addr),
        .i_data    (8'h00),
        .i_grant   (w_grant[REQ_R]),
        .o_pending (w_pend[REQ_R]),
        .o_addr    (w_slot_addr[REQ_R]),
        .o_data    (w_slot_data[REQ_R]),
        .o_ovf     (w_ovf_evt[REQ_R])
    );

    assign w_mcu_pend = w_pend[REQ_W] | w_pend[REQ_R];

    // Once DMA has used up its burst allowance, any pending MCU request wins.
    always_comb begin
        w_grant = '0;
        if (r_state == IDLE && slot_ok) begin
            if (r_burst_cnt == BURST_MAX && w_mcu_pend) begin
                if (w_pend[REQ_W]) begin
                    w_grant[REQ_W] = 1'b1;
                end else begin
                    w_grant[REQ_R] = 1'b1;
                end
            end else if (w_pend[REQ_DMA]) begin
                w_grant[REQ_DMA] = 1'b1;
            end else if (w_pend[REQ_W]) begin
                w_grant[REQ_W] = 1'b1;
            end else if (w_pend[REQ_R]) begin
                w_grant[REQ_R] = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_addr = w_slot_addr[REQ_DMA];
        w_sel_data = w_slot_data[REQ_DMA];
        if (w_grant[REQ_W]) begin
            w_sel_addr = w_slot_addr[REQ_W];
            w_sel_data = w_slot_data[REQ_W];
        end else if (w_grant[REQ_R]) begin
            w_sel_addr = w_slot_addr[REQ_R];
            w_sel_data = w_slot_data[REQ_R];
        end
    end

    assign w_acc_last = (r_acc_cnt == ACC_CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (|w_grant) w_next_state = SETUP;
            SETUP:   w_next_state = ACCESS;
            ACCESS:  if (w_acc_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_oe    <= 1'b0;
            r_acc_cnt   <= '0;
            r_burst_cnt <= '0;
            r_cur_dma   <= 1'b0;
            r_cur_rd    <= 1'b0;
            r_dma_ack   <= 1'b0;
            r_rq_rdy    <= 1'b0;
            r_rdata     <= '0;
            r_ovf       <= '0;
        end else begin
            r_dma_ack <= 1'b0;
            r_rq_rdy  <= 1'b0;
            // A new overflow on the clearing edge still sets its flag.
            r_ovf     <= ({3{~ovf_clr}} & r_ovf) | w_ovf_evt;
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_data;
                        r_cur_dma   <= w_grant[REQ_DMA];
                        r_cur_rd    <= w_grant[REQ_R];
                        if (w_grant[REQ_DMA]) begin
                            if (r_burst_cnt != BURST_MAX) begin
                                r_burst_cnt <= r_burst_cnt + BURST_CNT_W'(1);
                            end
                        end else begin
                            r_burst_cnt <= '0;
                        end
                    end
                end
                SETUP: begin
                    r_mem_we  <= ~r_cur_rd;
                    r_mem_oe  <= r_cur_rd;
                    r_acc_cnt <= ACC_LOAD;
                end
                ACCESS: begin
                    if (w_acc_last) begin
                        r_mem_we  <= 1'b0;
                        r_mem_oe  <= 1'b0;
                        r_dma_ack <= r_cur_dma;
                        r_rq_rdy  <= ~r_cur_dma;
                        if (r_cur_rd) begin
                            r_rdata <= mem_rdata;
                        end
                    end else begin
                        r_acc_cnt <= r_acc_cnt - ACC_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_we     = r_mem_we;
    assign mem_oe     = r_mem_oe;
    assign dma_ack    = r_dma_ack;
    assign mcu_rq_rdy = r_rq_rdy;
    assign mcu_rdata  = r_rdata;
    assign ovf        = r_ovf;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_mcu_mem_arb.sv
// Bench for mcu_mem_arb: directed scenarios plus randomized traffic checked
// against a transaction-level model of the pending slots and port occupancy.
module tb_mcu_mem_arb;

    localparam int AW = 24;
    localparam int AC = 2;
    localparam int BM = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          slot_ok, dma_req, mcu_rrq, mcu_wrq, ovf_clr;
    logic [AW-1:0] dma_addr, mcu_addr, mem_addr;
    logic [7:0]    dma_data, mcu_wdata, mem_wdata, mem_rdata, mcu_rdata;
    logic          dma_ack, mcu_rq_rdy, mem_we, mem_oe, busy;
    logic [2:0]    ovf;
    logic          rd_force;
    logic [7:0]    rd_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] hash(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5C;
    endfunction

    assign mem_rdata = rd_force ? rd_val : hash(mem_addr);

    mcu_mem_arb #(.ADDR_W(AW), .ACCESS_CYCLES(AC), .DMA_BURST_MAX(BM)) dut (
        .clk(clk), .rst_n(rst_n), .slot_ok(slot_ok),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_data(dma_data), .dma_ack(dma_ack),
        .mcu_rrq(mcu_rrq), .mcu_wrq(mcu_wrq), .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
        .mcu_rdata(mcu_rdata), .mcu_rq_rdy(mcu_rq_rdy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_oe(mem_oe), .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    // Reference model: pending slots plus an "elapsed cycles since grant" count.
    bit          m_pend  [3];
    logic [AW-1:0] m_paddr [3];
    logic [7:0]  m_pdata [3];
    bit          m_act;
    int          m_e, m_cur, m_burst;
    logic [AW-1:0] m_addr;
    logic [7:0]  m_wdata, m_rdata;
    logic [2:0]  m_ovf;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_pend[i] = 0;
        m_act = 0; m_e = 0; m_cur = 0; m_burst = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_ovf = '0;
    endtask

    task automatic model_step();
        logic [2:0]    pulse;
        logic [AW-1:0] in_a [3];
        logic [7:0]    in_d [3];
        logic [2:0]    set;
        int            g;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pulse = {mcu_rrq, mcu_wrq, dma_req};
        in_a[0] = dma_addr; in_a[1] = mcu_addr;  in_a[2] = mcu_addr;
        in_d[0] = dma_data; in_d[1] = mcu_wdata; in_d[2] = 8'h00;
        g = -1;
        if (!m_act) begin
            if (slot_ok) begin
                if (m_burst == BM && (m_pend[1] || m_pend[2])) g = m_pend[1] ? 1 : 2;
                else if (m_pend[0]) g = 0;
                else if (m_pend[1]) g = 1;
                else if (m_pend[2]) g = 2;
            end
        end else if (m_e == AC + 1) begin
            m_act = 0;
        end else begin
            m_e++;
            if (m_e == AC + 1 && m_cur == 2) m_rdata = rd_force ? rd_val : hash(m_addr);
        end
        if (g >= 0) begin
            m_act = 1; m_e = 0; m_cur = g;
            m_addr = m_paddr[g]; m_wdata = m_pdata[g];
            m_burst = (g == 0) ? ((m_burst < BM) ? m_burst + 1 : BM) : 0;
        end
        set = '0;
        for (int i = 0; i < 3; i++) begin
            if (pulse[i]) begin
                if (m_pend[i] && g != i) set[i] = 1'b1;
                else begin
                    m_pend[i] = 1; m_paddr[i] = in_a[i]; m_pdata[i] = in_d[i];
                end
            end else if (g == i) begin
                m_pend[i] = 0;
            end
        end
        m_ovf = (ovf_clr ? 3'b000 : m_ovf) | set;
    endtask

    function automatic logic [7:0] model_ctrl();
        logic strobe;
        strobe = m_act && m_e >= 1 && m_e <= AC;
        return {strobe && m_cur != 2, strobe && m_cur == 2,
                m_act && m_e == AC + 1 && m_cur == 0,
                m_act && m_e == AC + 1 && m_cur != 0,
                m_act, m_ovf};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        slot_ok = 0; dma_req = 0; mcu_rrq = 0; mcu_wrq = 0; ovf_clr = 0;
        dma_addr = '0; dma_data = '0; mcu_addr = '0; mcu_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        cyc(); cyc();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rd_force = 0; rd_val = 0;
        rst_n = 0;
        model_reset();
        @(negedge clk);
        checks++;
        if ({mem_we, mem_oe, dma_ack, mcu_rq_rdy, busy, ovf} !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0", {mem_we, mem_oe, dma_ack, mcu_rq_rdy, busy, ovf});
        end
        checks++;
        if ({mem_addr, mem_wdata, mcu_rdata} !== 40'h0) begin
            errors++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, mcu_rdata});
        end
        cyc();
        rst_n = 1;
        slot_ok = 1;
        cyc(); cyc();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle busy got %b exp 0", busy);
        end
    endtask

    task automatic test_single_read();
        logic [11:0]   oe_v, we_v, rdy_v, busy_v;
        logic [AW-1:0] a_s;
        logic [7:0]    d_s;
        do_reset();
        slot_ok = 1; rd_force = 1; rd_val = 8'hA5;
        mcu_addr = 24'h123456; mcu_rrq = 1;
        cyc();
        mcu_rrq = 0; mcu_addr = 24'h000000;
        a_s = '0; d_s = '0;
        for (int j = 0; j < 12; j++) begin
            oe_v[j] = mem_oe; we_v[j] = mem_we; rdy_v[j] = mcu_rq_rdy; busy_v[j] = busy;
            if (j == 1) a_s = mem_addr;
            if (j == 4) d_s = mcu_rdata;
            cyc();
        end
        checks++;
        if (oe_v !== 12'h00C || we_v !== 12'h000) begin
            errors++; $display("FAIL read_strobe oe %h we %h exp oe 00c we 000", oe_v, we_v);
        end
        checks++;
        if (rdy_v !== 12'h010) begin
            errors++; $display("FAIL read_rdy_latency got %h exp 010", rdy_v);
        end
        checks++;
        if (busy_v !== 12'h01E) begin
            errors++; $display("FAIL read_busy got %h exp 01e", busy_v);
        end
        checks++;
        if (a_s !== 24'h123456) begin
            errors++; $display("FAIL read_addr got %h exp 123456", a_s);
        end
        checks++;
        if (d_s !== 8'hA5 || mcu_rdata !== 8'hA5) begin
            errors++; $display("FAIL read_data got %h/%h exp a5", d_s, mcu_rdata);
        end
    endtask

    task automatic test_write_before_read();
        logic [13:0]   oe_v, we_v, rdy_v, busy_v;
        logic [AW-1:0] wa, ra;
        logic [7:0]    wd, rd;
        do_reset();
        slot_ok = 1; rd_force = 1; rd_val = 8'h5A;
        mcu_addr = 24'hABCDEF; mcu_wdata = 8'h3C; mcu_wrq = 1; mcu_rrq = 1;
        cyc();
        mcu_wrq = 0; mcu_rrq = 0; mcu_wdata = 8'h00;
        wa = '0; ra = '0; wd = '0; rd = '0;
        for (int j = 0; j < 14; j++) begin
            oe_v[j] = mem_oe; we_v[j] = mem_we; rdy_v[j] = mcu_rq_rdy; busy_v[j] = busy;
            if (j == 3) begin wa = mem_addr; wd = mem_wdata; end
            if (j == 8) ra = mem_addr;
            if (j == 9) rd = mcu_rdata;
            cyc();
        end
        checks++;
        if (we_v !== 14'h000C || oe_v !== 14'h0180) begin
            errors++; $display("FAIL wr_rd_order we %h oe %h exp we 000c oe 0180", we_v, oe_v);
        end
        checks++;
        if (rdy_v !== 14'h0210 || busy_v !== 14'h03DE) begin
            errors++; $display("FAIL wr_rd_rdy rdy %h busy %h exp rdy 0210 busy 03de", rdy_v, busy_v);
        end
        checks++;
        if (wa !== 24'hABCDEF || wd !== 8'h3C || ra !== 24'hABCDEF || rd !== 8'h5A) begin
            errors++; $display("FAIL wr_rd_data wa %h wd %h ra %h rd %h exp abcdef 3c abcdef 5a", wa, wd, ra, rd);
        end
        checks++;
        if (ovf !== 3'b000) begin
            errors++; $display("FAIL wr_rd_ovf got %b exp 000", ovf);
        end
    endtask

    task automatic test_overflow();
        int            acks;
        logic [AW-1:0] a_s;
        logic [7:0]    d_s;
        do_reset();
        rd_force = 0;
        dma_addr = 24'h000111; dma_data = 8'h11; dma_req = 1;
        cyc();
        dma_addr = 24'h000222; dma_data = 8'h22;
        cyc();
        dma_req = 0;
        checks++;
        if (ovf !== 3'b001 || busy !== 1'b0) begin
            errors++; $display("FAIL ovf_set ovf %b busy %b exp 001 0", ovf, busy);
        end
        ovf_clr = 1;
        cyc();
        ovf_clr = 0;
        checks++;
        if (ovf !== 3'b000) begin
            errors++; $display("FAIL ovf_clr got %b exp 000", ovf);
        end
        dma_addr = 24'h000333; dma_req = 1; ovf_clr = 1;
        cyc();
        dma_req = 0; ovf_clr = 0;
        checks++;
        if (ovf !== 3'b001) begin
            errors++; $display("FAIL ovf_set_wins got %b exp 001", ovf);
        end
        ovf_clr = 1;
        cyc();
        ovf_clr = 0;
        slot_ok = 1;
        acks = 0; a_s = '0; d_s = '0;
        for (int j = 0; j < 12; j++) begin
            if (dma_ack) acks++;
            if (mem_we) begin a_s = mem_addr; d_s = mem_wdata; end
            cyc();
        end
        checks++;
        if (acks != 1) begin
            errors++; $display("FAIL ovf_single_ack got %0d exp 1", acks);
        end
        checks++;
        if (a_s !== 24'h000111 || d_s !== 8'h11) begin
            errors++; $display("FAIL ovf_kept_first addr %h data %h exp 000111 11", a_s, d_s);
        end
    endtask

    task automatic test_slot_gating();
        bit any_we, any_busy;
        do_reset();
        mcu_addr = 24'h00C0DE; mcu_wdata = 8'h99; mcu_wrq = 1;
        cyc();
        mcu_wrq = 0;
        any_we = 0; any_busy = 0;
        for (int j = 0; j < 10; j++) begin
            any_we |= mem_we; any_busy |= busy;
            cyc();
        end
        checks++;
        if (any_we || any_busy) begin
            errors++; $display("FAIL gate_hold we %b busy %b exp 0 0", any_we, any_busy);
        end
        slot_ok = 1;
        cyc();
        checks++;
        if (busy !== 1'b1 || mem_we !== 1'b0) begin
            errors++; $display("FAIL gate_grant busy %b we %b exp 1 0", busy, mem_we);
        end
        slot_ok = 0;
        cyc();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 24'h00C0DE) begin
            errors++; $display("FAIL gate_no_abort we %b addr %h exp 1 00c0de", mem_we, mem_addr);
        end
        repeat (4) cyc();
    endtask

    task automatic test_burst();
        int          q[$];
        logic [11:0] order_v;
        do_reset();
        slot_ok = 1;
        dma_addr = 24'h100000; dma_data = 8'h01; dma_req = 1;
        cyc();
        dma_req = 0;
        mcu_addr = 24'h200000; mcu_wdata = 8'h77; mcu_wrq = 1;
        cyc();
        mcu_wrq = 0;
        for (int c = 0; c < 300 && q.size() < 12; c++) begin
            if (mcu_rq_rdy) q.push_back(1);
            if (dma_ack) q.push_back(0);
            dma_req = dma_ack && (q.size() < 12);
            dma_addr = 24'h100000 + AW'(c); dma_data = 8'(c);
            cyc();
        end
        dma_req = 0;
        checks++;
        if (q.size() < 12) begin
            errors++; $display("FAIL burst_timeout completions %0d exp 12", q.size());
        end
        order_v = '0;
        for (int i = 0; i < 12 && i < q.size(); i++) order_v[i] = (q[i] == 1);
        checks++;
        if (order_v !== 12'h100) begin
            errors++; $display("FAIL burst_order got %h exp 100", order_v);
        end
        repeat (8) cyc();
    endtask

    task automatic test_reset_mid();
        bit          seen, any_done;
        logic [7:0]  rdy_v, we_v;
        do_reset();
        slot_ok = 1;
        mcu_addr = 24'h00F00D; mcu_wdata = 8'h42; mcu_wrq = 1;
        cyc();
        mcu_wrq = 0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (mem_we) seen = 1;
            else cyc();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL rstmid_timeout we never rose");
        end
        rst_n = 0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_async we %b busy %b exp 0 0", mem_we, busy);
        end
        model_reset();
        @(negedge clk);
        any_done = 0;
        for (int j = 0; j < 3; j++) begin
            any_done |= dma_ack | mcu_rq_rdy;
            cyc();
        end
        rst_n = 1;
        for (int j = 0; j < 3; j++) begin
            any_done |= dma_ack | mcu_rq_rdy;
            cyc();
        end
        checks++;
        if (any_done || busy !== 1'b0 || ovf !== 3'b000 || mem_addr !== '0) begin
            errors++; $display("FAIL rstmid_cleared done %b busy %b ovf %b addr %h exp 0", any_done, busy, ovf, mem_addr);
        end
        mcu_addr = 24'h00BEEF; mcu_wdata = 8'h77; mcu_wrq = 1;
        cyc();
        mcu_wrq = 0;
        for (int j = 0; j < 8; j++) begin
            rdy_v[j] = mcu_rq_rdy; we_v[j] = mem_we;
            cyc();
        end
        checks++;
        if (rdy_v !== 8'h10 || we_v !== 8'h0C) begin
            errors++; $display("FAIL rstmid_fresh rdy %h we %h exp 10 0c", rdy_v, we_v);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_c;
        do_reset();
        rd_force = 0;
        for (int c = 0; c < 3000; c++) begin
            exp_c = model_ctrl();
            checks++;
            if ({mem_we, mem_oe, dma_ack, mcu_rq_rdy, busy, ovf} !== exp_c) begin
                errors++; $display("FAIL rand_ctrl cyc %0d got %b exp %b", c, {mem_we, mem_oe, dma_ack, mcu_rq_rdy, busy, ovf}, exp_c);
            end
            if (m_act) begin
                checks++;
                if (mem_addr !== m_addr) begin
                    errors++; $display("FAIL rand_addr cyc %0d got %h exp %h", c, mem_addr, m_addr);
                end
                if (m_cur != 2) begin
                    checks++;
                    if (mem_wdata !== m_wdata) begin
                        errors++; $display("FAIL rand_wdata cyc %0d got %h exp %h", c, mem_wdata, m_wdata);
                    end
                end
            end
            checks++;
            if (mcu_rdata !== m_rdata) begin
                errors++; $display("FAIL rand_rdata cyc %0d got %h exp %h", c, mcu_rdata, m_rdata);
            end
            slot_ok   = ($urandom_range(0, 3) != 0);
            dma_req   = ($urandom_range(0, 4) == 0);
            mcu_wrq   = ($urandom_range(0, 7) == 0);
            mcu_rrq   = ($urandom_range(0, 7) == 0);
            ovf_clr   = ($urandom_range(0, 19) == 0);
            dma_addr  = AW'($urandom);
            dma_data  = 8'($urandom);
            mcu_addr  = AW'($urandom);
            mcu_wdata = 8'($urandom);
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_before_read();
        test_overflow();
        test_slot_gating();
        test_burst();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcu_mem_arb.md
# mcu_mem_arb

Sequences the single MCU-side memory port between three requesters: SD DMA byte writes, MCU SPI write requests and MCU SPI read requests. Sits between the MCU command decoder (which issues `mcu_rrq`/`mcu_wrq` pulses and SD DMA write strobes) and the shared SRAM/ROM port. Each access runs as a fixed-length bus cycle, but only starts when the SNES-side slot indicator allows it. DMA has priority with bounded bursts so MCU accesses cannot starve.

## Interface
- `ADDR_W`, 24, memory address width
- `ACCESS_CYCLES`, 2, strobe-active cycles per access; legal 1..15
- `DMA_BURST_MAX`, 8, consecutive DMA grants before a pending MCU request must win; legal 1..255

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `slot_ok`  in  1  memory port free for MCU-side use this cycle
- `dma_req`  in  1  one-cycle pulse: DMA byte write request
- `dma_addr`  in  ADDR_W  DMA write address, valid with `dma_req`
- `dma_data`  in  8  DMA write data, valid with `dma_req`
- `dma_ack`  out  1  one-cycle pulse: DMA write completed
- `mcu_rrq`  in  1  one-cycle pulse: MCU read request
- `mcu_wrq`  in  1  one-cycle pulse: MCU write request
- `mcu_addr`  in  ADDR_W  MCU address, valid with `mcu_rrq`/`mcu_wrq`
- `mcu_wdata`  in  8  MCU write data, valid with `mcu_wrq`
- `mcu_rdata`  out  8  last MCU read result
- `mcu_rq_rdy`  out  1  one-cycle pulse: MCU read or write completed
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  8  memory write data
- `mem_rdata`  in  8  memory read data
- `mem_we`  out  1  write strobe, active high
- `mem_oe`  out  1  read strobe, active high
- `busy`  out  1  FSM not in IDLE
- `ovf`  out  3  sticky overflow flags {R, W, DMA}
- `ovf_clr`  in  1  clears `ovf`

## Operation
- **Request capture**
  - Each requester has one pending slot holding address and data, plus a pending bit.
  - A pulse sets the pending bit and captures address and data.
  - A pulse while the slot is already pending, and that slot is not being granted on the same edge, sets the corresponding `ovf` bit. The original request is kept; the new one is dropped.
  - A pulse on the same edge that the slot is granted re-arms the slot with the new request.
- **Arbitration**
  - Evaluated only in IDLE with `slot_ok`=1.
  - Default order: DMA, then MCU write, then MCU read.
  - `burst_cnt` counts consecutive DMA grants. When `burst_cnt`==DMA_BURST_MAX and any MCU slot is pending, the MCU slot wins (write before read).
  - `burst_cnt` clears on any MCU grant and saturates at DMA_BURST_MAX.
- **FSM: IDLE → SETUP → ACCESS → DONE → IDLE**
  - IDLE→SETUP on a grant. The granted slot's pending bit clears. `mem_addr`/`mem_wdata` load from the slot.
  - SETUP→ACCESS unconditionally. `mem_we` (write) or `mem_oe` (read) asserts; the access counter loads ACCESS_CYCLES.
  - ACCESS holds the strobe for ACCESS_CYCLES cycles, then moves to DONE. On that edge the strobe deasserts; for a read, `mem_rdata` is captured into `mcu_rdata`.
  - DONE pulses `dma_ack` or `mcu_rq_rdy` for one cycle, then returns to IDLE. `mem_addr` holds until the next grant.
- `ovf_clr` clears all flags. If it coincides with a new overflow event, the set wins.

## Timing
- **Reset values:** all outputs 0; FSM in IDLE; pending bits, `burst_cnt` and `ovf` cleared.
- **Reset mid-access:** `mem_we`/`mem_oe` drop asynchronously with `rst_n`, and no ack is issued.
- **Latency:** request pulse at edge k with `slot_ok`=1 and the FSM idle:
  - SETUP at k+1
  - strobe high from k+2 to k+2+ACCESS_CYCLES
  - ack high in the cycle after edge k+2+ACCESS_CYCLES (k+4 for the default).
- **Occupancy:** one access occupies the port for ACCESS_CYCLES+3 cycles. Back-to-back grants are possible, with IDLE lasting one cycle.
- **Arbitration gating:** `slot_ok` is sampled only in IDLE. Deassertion after the grant does not abort the access.
- **Port stability:** `mem_addr` and `mem_wdata` are stable from SETUP through DONE.

## Structure
- Shared package `mcu_arb_pkg`:
  - state enum (IDLE/SETUP/ACCESS/DONE)
  - requester index constants REQ_DMA=0, REQ_W=1, REQ_R=2
  - widths of the access counter (4) and `burst_cnt` (8)
- Sub-module `mcu_arb_slot`: one pending slot, holding address/data registers, the pending bit and the overflow detect. Instantiated three times (the read slot ignores data).

## Test plan
- **Single MCU read:** ACCESS_CYCLES=2, `mcu_rrq` with addr 0x123456, `mem_rdata`=0xA5 → `mem_oe` high for 2 cycles, `mcu_rq_rdy` 4 cycles after the request edge, `mcu_rdata`=0xA5.
- **Bounded DMA burst:** `dma_req` every 5 cycles (one per completed access, so the DMA slot never overflows), plus a single `mcu_wrq` → MCU write granted exactly after the 8th consecutive DMA grant, then DMA resumes.
- **Write-before-read:** `mcu_wrq` and `mcu_rrq` on the same edge → write completes first, read second, two `mcu_rq_rdy` pulses, `ovf`=0.
- **Overflow:** two `dma_req` pulses 1 cycle apart with `slot_ok`=0 → `ovf`=3'b001; `ovf_clr` → 0; a single `dma_ack` after `slot_ok` rises.
- **Slot gating:** `mcu_wrq` with `slot_ok`=0 for 10 cycles → no strobe and `busy`=0; grant on the first `slot_ok`=1 cycle.
- **Reset mid-access:** assert `rst_n`=0 during ACCESS of a write → `mem_we` falls immediately, no ack, all state cleared; a fresh request after release completes normally.
